bmem_arbiter: RTL
=================

// Module: bmem_arbiter
// PURPOSE
//  Shares the single burst-memory port (bmem_*) between the I-cache and D-cache line-fill/writeback paths.
//  Arbitrates between the two requesters, one transaction at a time.
//  Converts each 256-bit line transaction into a burst of four 64-bit beats, and assembles read beats back into a line.
//  Sits inside mp4, between the caches and the top-level bmem_* ports.
// PARAMETERS
//  LINE_W  256  cache line width, bits
//  BEAT_W  64   burst-memory data width, bits
//  BEATS   LINE_W/BEAT_W (4)  beats per line transaction
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset: synchronous, active-high
//  i_addr        in   32      I-cache line address
//  i_read        in   1       I-cache line read request, level, held until i_resp
//  i_rdata       out  LINE_W  assembled line for I-cache
//  i_resp        out  1       one-cycle completion pulse to I-cache
//  d_addr        in   32      D-cache line address
//  d_read        in   1       D-cache line read request, level
//  d_write       in   1       D-cache line writeback request, level
//  d_wdata       in   LINE_W  writeback line, held stable until d_resp
//  d_rdata       out  LINE_W  assembled line for D-cache
//  d_resp        out  1       one-cycle completion pulse to D-cache
//  bmem_address  out  32      burst address, line-aligned ([4:0]=0)
//  bmem_read     out  1       burst read command
//  bmem_write    out  1       burst write beat valid
//  bmem_wdata    out  BEAT_W  write beat
//  bmem_rdata    in   BEAT_W  read beat
//  bmem_resp     in   1       read beat valid / write ack
// BEHAVIOUR
//  Reset state: state=IDLE, beat=0, last_grant=D.
//  Outputs at reset: bmem_read/bmem_write/i_resp/d_resp=0; bmem_address/bmem_wdata/i_rdata/d_rdata=0.
//  FSM states: IDLE, RD_CMD, RD_BEATS, WR_BEATS, WR_ACK, DONE.
//  IDLE: sample i_read, d_read|d_write.
//   - One pending: grant it.
//   - Both pending: grant the one NOT in last_grant (2-way round-robin).
//   - On grant: latch addr&~32'h1F, requester id and op into regs; update last_grant.
//   - D op: d_write=1 -> write, takes priority over d_read (both high is illegal; assert).
//  RD_CMD: bmem_read=1 for exactly one cycle with latched addr -> RD_BEATS, beat=0.
//  RD_BEATS: each cycle with bmem_resp=1, line[beat*64 +: 64] <= bmem_rdata; beat++.
//   - Beat 0 goes to bits [63:0].
//   - Cycles with bmem_resp=0 are stalls and capture nothing.
//   - On 4th beat -> DONE.
//  WR_BEATS: bmem_write=1 for 4 consecutive cycles, address constant.
//   - bmem_wdata = d_wdata[beat*64 +: 64], beat 0..3.
//   - After beat 3 -> WR_ACK.
//  WR_ACK: bmem_write=0; wait for bmem_resp=1 -> DONE.
//  DONE: assert i_resp or d_resp (granted side only) for exactly 1 cycle -> IDLE.
//   - Read: i_rdata/d_rdata hold the assembled line from the DONE cycle until the next read to that side completes.
//   - Requests are not sampled in DONE; the requester drops its request the cycle after resp.
//   - Back-to-back transactions are therefore separated by one idle cycle.
//  Latency, read: grant +1 (RD_CMD) + memory latency + 4 beats + 1 (DONE).
//  Latency, write: grant +1, +4 beats, + ack wait, + 1 (DONE).
//  A requester deasserting mid-transaction is ignored; the transaction completes and resp still pulses.
//  bmem_resp in IDLE/RD_CMD/WR_BEATS/DONE is ignored; no capture, no state change.
//  rst mid-transaction: FSM to IDLE on that edge; all strobes low next cycle; in-flight beats dropped.
//  At most one of bmem_read/bmem_write high in any cycle; i_resp and d_resp never high together.
// TESTING
//  1. I read 0x6000_0044, beats 0..3 = 0x11..,0x22..,0x33..,0x44..
//     -> bmem_address=0x6000_0040, one-cycle bmem_read.
//     -> i_rdata[63:0]=0x11.., [255:192]=0x44.., i_resp 1 cycle.
//  2. D write 0x6000_0100, wdata={4{beat k}}
//     -> 4 consecutive bmem_write cycles carrying words 0..3 in order.
//     -> d_resp one cycle after bmem_resp ack.
//  3. i_read and d_read raised same cycle after reset (last_grant=D)
//     -> I served first, then D; never two bmem_read in flight.
//  4. Read with bmem_resp gaps (beat, 2 stall cycles, 3 beats)
//     -> line assembled correctly; no capture on stall cycles.
//  5. rst asserted during RD_BEATS after 2 beats
//     -> IDLE next cycle, no resp; next read returns fresh line with beat index restarted at 0.
//  6. d_read dropped mid-burst
//     -> burst completes, d_resp pulses once; arbiter back in IDLE with bmem strobes low.

Source files
------------

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the burst-memory port between I-cache and D-cache.
// Round-robin between the two requesters, one line transaction at a time;
// each 256-bit line moves as four 64-bit beats, read beats are assembled
// back into a line.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_addr, i_read            I-cache line read request (level)
//   i_rdata, i_resp           assembled line and one-cycle completion pulse
//   d_addr, d_read, d_write   D-cache line read / writeback request (level)
//   d_wdata                   writeback line, stable until d_resp
//   d_rdata, d_resp           assembled line and one-cycle completion pulse
//   bmem_address              line-aligned burst address
//   bmem_read                 one-cycle burst read command
//   bmem_write, bmem_wdata    write beat valid and data
//   bmem_rdata, bmem_resp     read beat data / valid, or write ack
module bmem_arbiter #(
    parameter  int LINE_W = 256,
    parameter  int BEAT_W = 64,
    localparam int BEATS  = LINE_W / BEAT_W,
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEATS,
        WR_BEATS,
        WR_ACK,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              last_d_q, last_d_d;   // 1: D-cache won last grant
    logic              gnt_d_q, gnt_d_d;     // 1: current owner is D-cache
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;       // read assembly buffer
    logic [LINE_W-1:0] irdata_q, irdata_d;
    logic [LINE_W-1:0] drdata_q, drdata_d;

    logic d_pend;
    logic pick_d;
    logic last_beat;

    assign d_pend    = d_read | d_write;
    // Both pending: the side that did not win last time goes first.
    assign pick_d    = d_pend & (~i_read | ~last_d_q);
    assign last_beat = (beat_q == BW'(BEATS - 1));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d_d = last_d_q;
        gnt_d_d  = gnt_d_q;
        addr_d   = addr_q;
        line_d   = line_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_read || d_pend) begin
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    addr_d   = (pick_d ? d_addr : i_addr) & ~32'h1F;
                    beat_d   = '0;
                    // Writeback wins over a read on the D side.
                    state_d  = (pick_d && d_write) ? WR_BEATS : RD_CMD;
                end
            end
            RD_CMD: begin
                beat_d  = '0;
                state_d = RD_BEATS;
            end
            RD_BEATS: begin
                if (bmem_resp) begin
                    line_d[int'(beat_q)*BEAT_W +: BEAT_W] = bmem_rdata;
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        // Publish the line so it is visible in DONE and
                        // stays put until the next read to that side.
                        if (gnt_d_q) drdata_d = line_d;
                        else         irdata_d = line_d;
                        state_d = DONE;
                    end
                end
            end
            WR_BEATS: begin
                beat_d = beat_q + BW'(1);
                if (last_beat) state_d = WR_ACK;
            end
            WR_ACK: begin
                if (bmem_resp) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_d_q <= 1'b1;
            gnt_d_q  <= 1'b0;
            addr_q   <= '0;
            line_q   <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_d_q <= last_d_d;
            gnt_d_q  <= gnt_d_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign bmem_address = addr_q;
    assign bmem_read    = (state_q == RD_CMD);
    assign bmem_write   = (state_q == WR_BEATS);
    assign bmem_wdata   = bmem_write ?
                          d_wdata[int'(beat_q)*BEAT_W +: BEAT_W] : '0;
    assign i_resp       = (state_q == DONE) & ~gnt_d_q;
    assign d_resp       = (state_q == DONE) &  gnt_d_q;
    assign i_rdata      = irdata_q;
    assign d_rdata      = drdata_q;

    // A D-cache read and writeback at the same time is a protocol error.
    a_d_rw_excl : assert property (
        @(posedge clk) disable iff (rst) !(d_read && d_write)
    );

endmodule
